bus_s2p_rx: RTL and testbench

- Parametrised serial-to-parallel receiver for the system bus.
- Deserialises a frame carried on two parallel serial lines, address and data, into one registered parallel word pair.
- Adds to the earlier fixed 12/8-bit converter:
  - explicit frame qualification (rx_valid)
  - a one-deep output buffer with a valid/ready handshake
  - abort and overrun detection
- Sits between the bus serial lines and a slave's parallel register interface.

---
 rtl/bus_s2p_rx.sv | 139 +++++++++++++
 tb/tb_bus_s2p_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_s2p_rx.sv
// Serial-to-parallel bus receiver: address/data lines deserialised LSB first into a
// one-deep valid/ready output buffer. Define BUS_S2P_PARITY_EN to add a trailing even-parity slot.
module bus_s2p_rx #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic              rx_address,
   input  logic              rx_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [ADDR_W-1:0] address_out,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun,
   output logic              parity_err
);

   localparam int unsigned FRAME_LEN = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
`ifdef BUS_S2P_PARITY_EN
   localparam int unsigned LAST_SLOT = FRAME_LEN;
`else
   localparam int unsigned LAST_SLOT = FRAME_LEN - 1;
`endif
   localparam int unsigned CW = $clog2(LAST_SLOT + 1);
   localparam logic [CW-1:0] LAST = CW'(LAST_SLOT);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
   logic [DATA_W-1:0] data_sh_q, data_sh_d;
   logic              out_valid_q;
   logic [ADDR_W-1:0] addr_out_q;
   logic [DATA_W-1:0] data_out_q;
   logic              frame_err_q;
   logic              overrun_q;
   logic              last_slot;
   logic              frame_ok;

   // Shift image including the bit on the lines this cycle, so the output can load on the last-bit edge.
   always_comb begin
      addr_sh_d = (state_q == IDLE) ? '0 : addr_sh_q;
      data_sh_d = (state_q == IDLE) ? '0 : data_sh_q;
      for (int unsigned i = 0; i < ADDR_W; i++)
         if (cnt_q == CW'(i)) addr_sh_d[i] = rx_address;
      for (int unsigned i = 0; i < DATA_W; i++)
         if (cnt_q == CW'(i)) data_sh_d[i] = rx_data;
      last_slot = (state_q == SHIFT) && (cnt_q == LAST);
   end

`ifdef BUS_S2P_PARITY_EN
   logic parity_err_q;
   // In the parity slot the payload is already complete in the shift registers.
   assign frame_ok   = ~(^addr_sh_q ^ ^data_sh_q ^ rx_data);
   assign parity_err = parity_err_q;
`else
   assign frame_ok   = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_sh_q   <= '0;
         data_sh_q   <= '0;
         out_valid_q <= 1'b0;
         addr_out_q  <= '0;
         data_out_q  <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef BUS_S2P_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef BUS_S2P_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         if (out_valid_q && out_ready)
            out_valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (rx_valid) begin
                  addr_sh_q <= addr_sh_d;
                  data_sh_q <= data_sh_d;
                  cnt_q     <= CW'(1);
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (!rx_valid) begin
                  frame_err_q <= 1'b1;
                  addr_sh_q   <= '0;
                  data_sh_q   <= '0;
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end else if (last_slot) begin
                  addr_sh_q <= '0;
                  data_sh_q <= '0;
                  cnt_q     <= '0;
                  state_q   <= IDLE;
                  if (!frame_ok) begin
`ifdef BUS_S2P_PARITY_EN
                     parity_err_q <= 1'b1;
`endif
                  end else if (!out_valid_q || out_ready) begin
                     addr_out_q  <= addr_sh_d;
                     data_out_q  <= data_sh_d;
                     out_valid_q <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end else begin
                  addr_sh_q <= addr_sh_d;
                  data_sh_q <= data_sh_d;
                  cnt_q     <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid   = out_valid_q;
   assign address_out = addr_out_q;
   assign data_out    = data_out_q;
   assign busy        = (state_q == SHIFT);
   assign frame_err   = frame_err_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_bus_s2p_rx.sv
// Scoreboard bench for bus_s2p_rx: expected words queued by stimulus, popped by a
// handshake monitor; error pulses counted by the monitor and checked by stimulus.
module tb_bus_s2p_rx;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;
`ifdef BUS_S2P_PARITY_EN
   localparam int unsigned NSLOT = 13;
`else
   localparam int unsigned NSLOT = 12;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_valid;
   logic          rx_address;
   logic          rx_data;
   logic          out_ready;
   logic          out_valid;
   logic [AW-1:0] address_out;
   logic [DW-1:0] data_out;
   logic          busy;
   logic          frame_err;
   logic          overrun;
   logic          parity_err;

   always #5 clk = ~clk;

   bus_s2p_rx #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_address(rx_address),
      .rx_data(rx_data), .out_ready(out_ready), .out_valid(out_valid),
      .address_out(address_out), .data_out(data_out), .busy(busy),
      .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } word_t;

   word_t exp_q[$];
   word_t mon_w;
   int    checks = 0;
   int    errors = 0;
   int    n_ferr = 0;
   int    n_ovr  = 0;
   int    n_perr = 0;
   int    base;
   int    unstable;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: samples on the falling edge, pops on every accepted word.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err)  n_ferr++;
         if (overrun)    n_ovr++;
         if (parity_err) n_perr++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h/%0h expected none", address_out, data_out);
            end else begin
               mon_w = exp_q.pop_front();
               check("word_addr", 32'(address_out), 32'(mon_w.a));
               check("word_data", 32'(data_out), 32'(mon_w.d));
            end
         end
      end
   end

   task automatic slot(input logic v, input logic a, input logic d);
      rx_valid   = v;
      rx_address = a;
      rx_data    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) slot(1'b0, 1'b0, 1'b0);
   endtask

   // Sends the first nslots slots of a frame; unused data slots 8..11 carry 1.
   task automatic frame(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic par,
                        input int unsigned nslots, input logic ready_last);
      for (int unsigned i = 0; i < nslots; i++) begin
         if (ready_last && i == nslots - 1) out_ready = 1'b1;
         if (i < AW) slot(1'b1, a[i[3:0]], (i < DW) ? d[i[2:0]] : 1'b1);
         else        slot(1'b1, 1'b0, par);
      end
   endtask

   function automatic logic epar(input logic [AW-1:0] a, input logic [DW-1:0] d);
      return ^a ^ ^d;
   endfunction

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_address = 1'b0; rx_data = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_addr", 32'(address_out), 0);
      check("rst_data", 32'(data_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 0);
      rst = 1'b0;
      idle(2);

      // Basic frame, consumer ready
      out_ready = 1'b1;
      exp_q.push_back('{a: 12'hA5C, d: 8'h3C});
      frame(12'hA5C, 8'h3C, epar(12'hA5C, 8'h3C), NSLOT, 1'b0);
      check("t1_valid", 32'(out_valid), 1);
      check("t1_addr", 32'(address_out), 32'h A5C);
      check("t1_data", 32'(data_out), 32'h3C);
      check("t1_busy", 32'(busy), 0);
      idle(2);
      check("t1_valid_clr", 32'(out_valid), 0);

      // Stall for 20 cycles then accept once
      out_ready = 1'b0;
      exp_q.push_back('{a: 12'hA5C, d: 8'h3C});
      frame(12'hA5C, 8'h3C, epar(12'hA5C, 8'h3C), NSLOT, 1'b0);
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         slot(1'b0, 1'b0, 1'b0);
         if (out_valid !== 1'b1 || address_out !== 12'hA5C || data_out !== 8'h3C) unstable++;
      end
      check("t2_stable", 32'(unstable), 0);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      check("t2_valid_clr", 32'(out_valid), 0);

      // Abort after 5 slots, then a clean frame
      base = n_ferr;
      frame(12'h7FF, 8'hFF, 1'b0, 5, 1'b0);
      check("t3_busy_mid", 32'(busy), 1);
      idle(3);
      check("t3_ferr_pulses", 32'(n_ferr - base), 1);
      check("t3_valid", 32'(out_valid), 0);
      check("t3_busy", 32'(busy), 0);
      out_ready = 1'b1;
      exp_q.push_back('{a: 12'h123, d: 8'h45});
      frame(12'h123, 8'h45, epar(12'h123, 8'h45), NSLOT, 1'b0);
      idle(2);
      out_ready = 1'b0;

      // Back-to-back with consumer stalled: second frame overruns
      base = n_ovr;
      exp_q.push_back('{a: 12'h001, d: 8'h11});
      frame(12'h001, 8'h11, epar(12'h001, 8'h11), NSLOT, 1'b0);
      frame(12'h002, 8'h22, epar(12'h002, 8'h22), NSLOT, 1'b0);
      idle(3);
      check("t4_ovr_pulses", 32'(n_ovr - base), 1);
      check("t4_valid", 32'(out_valid), 1);
      check("t4_addr_kept", 32'(address_out), 32'h001);
      check("t4_data_kept", 32'(data_out), 32'h11);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;

      // Back-to-back with accept on the completion edge: reload, no overrun
      base = n_ovr;
      exp_q.push_back('{a: 12'h001, d: 8'h11});
      exp_q.push_back('{a: 12'h002, d: 8'h22});
      frame(12'h001, 8'h11, epar(12'h001, 8'h11), NSLOT, 1'b0);
      frame(12'h002, 8'h22, epar(12'h002, 8'h22), NSLOT, 1'b1);
      out_ready = 1'b0;
      check("t4b_valid", 32'(out_valid), 1);
      check("t4b_addr", 32'(address_out), 32'h002);
      check("t4b_data", 32'(data_out), 32'h22);
      idle(3);
      check("t4b_no_ovr", 32'(n_ovr - base), 0);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      check("t4b_valid_clr", 32'(out_valid), 0);

      // Reset mid-frame with a word buffered
      frame(12'h7E5, 8'h5A, epar(12'h7E5, 8'h5A), NSLOT, 1'b0);
      frame(12'h3C3, 8'h99, 1'b0, 6, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("t5_valid", 32'(out_valid), 0);
      check("t5_addr", 32'(address_out), 0);
      check("t5_data", 32'(data_out), 0);
      check("t5_busy", 32'(busy), 0);
      idle(2);
      check("t5_no_abort", 32'(frame_err), 0);
      out_ready = 1'b1;
      exp_q.push_back('{a: 12'hFFF, d: 8'hFF});
      frame(12'hFFF, 8'hFF, epar(12'hFFF, 8'hFF), NSLOT, 1'b0);
      check("t5_valid_after", 32'(out_valid), 1);
      idle(2);

`ifdef BUS_S2P_PARITY_EN
      exp_q.push_back('{a: 12'h001, d: 8'h01});
      frame(12'h001, 8'h01, 1'b0, NSLOT, 1'b0);
      check("t6_good_valid", 32'(out_valid), 1);
      idle(2);
      base = n_perr;
      frame(12'h001, 8'h01, 1'b1, NSLOT, 1'b0);
      check("t6_bad_valid", 32'(out_valid), 0);
      idle(2);
      check("t6_perr_pulses", 32'(n_perr - base), 1);
      check("t6_perr_total", 32'(n_perr), 1);
`else
      check("perr_never", 32'(n_perr), 0);
`endif
      out_ready = 1'b0;
      idle(3);
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      check("ovr_total", 32'(n_ovr), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
